mem_bus_sequencer: RTL and testbench
====================================

Name: mem_bus_sequencer

Overview:
Bus-cycle controller for the 8085 memory subsystem.
- Watches the multiplexed AD bus, latches the full 16-bit address on ALE and decodes it into ROM, RAM, I/O or unmapped.
- Drives device chip-selects and inserts a per-region number of wait states through READY.
- Arbitrates the bus between the CPU and a single DMA requester using a HOLD/HLDA handshake.

Parameters:
ROM_END, 16'h07FF, last ROM address; ROM spans 16'h0000..ROM_END
RAM_BASE, 16'h2000, first RAM address
RAM_END, 16'h27FF, last RAM address
WAIT_W, 3, wait-counter width in bits
ROM_WAIT, 2, wait states for a ROM access
RAM_WAIT, 0, wait states for a RAM access
IO_WAIT, 1, wait states for an I/O access

Ports:
CLK  in  1  clock; all state updates on the rising edge
RESET  in  1  reset; synchronous, active-high
ALE  in  1  address latch enable from CPU
AD_IN  in  8  low address/data bus, sampled only when ALE=1
A_HI  in  8  high address A[15:8]
IO_Mn  in  1  1 = I/O cycle, 0 = memory cycle
RDn  in  1  read strobe, active low
WRn  in  1  write strobe, active low
HLDA  in  1  hold acknowledge from CPU
DMA_REQ  in  1  DMA bus request
ADDR_LATCHED  out  16  latched address {A_HI, AD_IN}
READY  out  1  CPU ready; 0 inserts a wait state
ROM_CSn  out  1  ROM select, active low
RAM_CSn  out  1  RAM select, active low
IO_CSn  out  1  I/O select, active low
HOLD  out  1  hold request to CPU
DMA_GNT  out  1  bus granted to DMA
BUS_ERR  out  1  one-cycle error pulse

Behaviour:
- Reset values: ADDR_LATCHED=16'h0000, READY=1, all CSn=1, HOLD=0, DMA_GNT=0, BUS_ERR=0, state IDLE, wait counter 0.
- Reset asserted mid-cycle or mid-DMA forces the reset values on the next edge.
- States: IDLE, DECODE, WAIT, DONE, HREQ, HGNT.
- IDLE:
  - ALE=1: latch ADDR_LATCHED and IO_Mn, register the region, go to DECODE.
  - Else DMA_REQ=1: HOLD<=1, go to HREQ.
  - ALE and DMA_REQ in the same cycle: the CPU cycle wins and DMA_REQ is re-sampled after the cycle.
- Region decode, in priority order:
  - IO_Mn=1 → IO.
  - Address ≤ROM_END → ROM.
  - RAM_BASE..RAM_END inclusive → RAM.
  - Otherwise → UNMAPPED.
- DECODE waits for the first cycle with RDn=0 or WRn=0. On that edge:
  - Legal mapped access: assert the region CSn=0 and load the counter with the region wait value. Value 0 → READY stays 1, go to DONE. Value N>0 → READY<=0, go to WAIT.
  - Illegal cases (UNMAPPED, write to ROM, or RDn=0 and WRn=0 together): no CS asserted, BUS_ERR=1 for exactly one cycle, READY stays 1, go to DONE.
- WAIT: decrement the counter each cycle. READY is low for exactly N consecutive cycles, then READY<=1 and go to DONE. CS stays asserted throughout.
- DONE:
  - CS held until RDn=1 and WRn=1 are both sampled. On that edge all CSn<=1.
  - If ALE=1 on that same edge: latch the new address and go directly to DECODE. Otherwise go to IDLE.
- HREQ: hold HOLD=1 until HLDA=1, then DMA_GNT<=1 and go to HGNT.
  - If DMA_REQ drops before HLDA: HOLD<=0, return to IDLE.
- HGNT:
  - All CSn=1, READY=1, ALE ignored.
  - When DMA_REQ=0: DMA_GNT<=0 and HOLD<=0 on the same edge, then remain in HGNT until HLDA=0, then go to IDLE.
- Counter arithmetic: WAIT_W bits, unsigned. Wait parameters must be ≤2^WAIT_W−1; elaboration error otherwise. No wrap is possible.
- BUS_ERR never lasts longer than one cycle per bus cycle.

Test Plan:
- ROM read at 16'h0123 (ALE, then RDn=0): ROM_CSn=0; READY low exactly 2 cycles; then READY=1; ROM_CSn returns to 1 the edge after RDn=1.
- RAM write at 16'h2010 with RAM_WAIT=0: RAM_CSn=0 with no READY drop; ADDR_LATCHED=16'h2010; BUS_ERR stays 0.
- Write to ROM address 16'h0005, and separately a read at 16'h4000: no CS asserted, BUS_ERR pulses for 1 cycle, READY stays 1.
- I/O read at port 8'h42 (IO_Mn=1, address 16'h4242): IO_CSn=0, READY low 1 cycle, ROM_CSn and RAM_CSn stay 1.
- DMA_REQ=1 with ALE=1 in the same IDLE cycle: the CPU cycle completes first, then HOLD=1. HLDA=1 → DMA_GNT=1. DMA_REQ=0 → HOLD=0 and DMA_GNT=0 on the same edge. HLDA=0 → back to IDLE.
- RESET pulsed during ROM WAIT (counter=1): next edge READY=1, ROM_CSn=1, state IDLE, ADDR_LATCHED=16'h0000.

Source files
------------

// File: rtl/mem_bus_sequencer.sv
// 8085 bus-cycle controller: latches/decodes the address, drives chip-selects,
// inserts per-region wait states and arbitrates the bus with one DMA requester.
module mem_bus_sequencer #(
    parameter logic [15:0] ROM_END  = 16'h07FF,
    parameter logic [15:0] RAM_BASE = 16'h2000,
    parameter logic [15:0] RAM_END  = 16'h27FF,
    parameter int          WAIT_W   = 3,
    parameter int          ROM_WAIT = 2,
    parameter int          RAM_WAIT = 0,
    parameter int          IO_WAIT  = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic [7:0]  AD_IN,
    input  logic [7:0]  A_HI,
    input  logic        IO_Mn,
    input  logic        RDn,
    input  logic        WRn,
    input  logic        HLDA,
    input  logic        DMA_REQ,
    output logic [15:0] ADDR_LATCHED,
    output logic        READY,
    output logic        ROM_CSn,
    output logic        RAM_CSn,
    output logic        IO_CSn,
    output logic        HOLD,
    output logic        DMA_GNT,
    output logic        BUS_ERR
);

    localparam int WAIT_MAX = (2 ** WAIT_W) - 1;

    if (ROM_WAIT < 0 || ROM_WAIT > WAIT_MAX ||
        RAM_WAIT < 0 || RAM_WAIT > WAIT_MAX ||
        IO_WAIT  < 0 || IO_WAIT  > WAIT_MAX) begin : g_bad_wait
        $error("wait-state parameter does not fit in WAIT_W bits");
    end

    localparam logic [WAIT_W-1:0] ROM_WAIT_V = WAIT_W'(ROM_WAIT);
    localparam logic [WAIT_W-1:0] RAM_WAIT_V = WAIT_W'(RAM_WAIT);
    localparam logic [WAIT_W-1:0] IO_WAIT_V  = WAIT_W'(IO_WAIT);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_DONE, S_HREQ, S_HGNT} state_t;
    typedef enum logic [1:0] {R_ROM, R_RAM, R_IO, R_UNMAP} region_t;

    state_t            state;
    region_t           region;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_val;
    logic [15:0]       bus_addr;
    logic              strobe;
    logic              bad_access;

    function automatic region_t decode(input logic io, input logic [15:0] a);
        if (io)                            return R_IO;
        else if (a <= ROM_END)             return R_ROM;
        else if (a >= RAM_BASE && a <= RAM_END) return R_RAM;
        else                               return R_UNMAP;
    endfunction

    function automatic logic [WAIT_W-1:0] region_wait(input region_t r);
        case (r)
            R_ROM:   return ROM_WAIT_V;
            R_RAM:   return RAM_WAIT_V;
            R_IO:    return IO_WAIT_V;
            default: return '0;
        endcase
    endfunction

    assign bus_addr   = {A_HI, AD_IN};
    assign wait_val   = region_wait(region);
    assign strobe     = !RDn || !WRn;
    // Both strobes together is a malformed cycle, never a legal access.
    assign bad_access = (region == R_UNMAP) || (region == R_ROM && !WRn) || (!RDn && !WRn);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_IDLE;
            region       <= R_UNMAP;
            wait_cnt     <= '0;
            ADDR_LATCHED <= 16'h0000;
            READY        <= 1'b1;
            ROM_CSn      <= 1'b1;
            RAM_CSn      <= 1'b1;
            IO_CSn       <= 1'b1;
            HOLD         <= 1'b0;
            DMA_GNT      <= 1'b0;
            BUS_ERR      <= 1'b0;
        end else begin
            BUS_ERR <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ALE) begin
                        ADDR_LATCHED <= bus_addr;
                        region       <= decode(IO_Mn, bus_addr);
                        state        <= S_DECODE;
                    end else if (DMA_REQ) begin
                        HOLD  <= 1'b1;
                        state <= S_HREQ;
                    end
                end
                S_DECODE: begin
                    if (strobe) begin
                        if (bad_access) begin
                            BUS_ERR <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            case (region)
                                R_ROM:   ROM_CSn <= 1'b0;
                                R_RAM:   RAM_CSn <= 1'b0;
                                R_IO:    IO_CSn  <= 1'b0;
                                default: ;
                            endcase
                            wait_cnt <= wait_val;
                            if (wait_val == '0) begin
                                state <= S_DONE;
                            end else begin
                                READY <= 1'b0;
                                state <= S_WAIT;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    // READY dropped on the decode edge, so release on the Nth wait edge.
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == WAIT_W'(1)) begin
                        READY <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (RDn && WRn) begin
                        ROM_CSn <= 1'b1;
                        RAM_CSn <= 1'b1;
                        IO_CSn  <= 1'b1;
                        if (ALE) begin
                            ADDR_LATCHED <= bus_addr;
                            region       <= decode(IO_Mn, bus_addr);
                            state        <= S_DECODE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_HREQ: begin
                    if (!DMA_REQ) begin
                        HOLD  <= 1'b0;
                        state <= S_IDLE;
                    end else if (HLDA) begin
                        DMA_GNT <= 1'b1;
                        state   <= S_HGNT;
                    end
                end
                S_HGNT: begin
                    // DMA_GNT doubles as the sub-phase: granted, then waiting for HLDA to fall.
                    if (DMA_GNT) begin
                        if (!DMA_REQ) begin
                            DMA_GNT <= 1'b0;
                            HOLD    <= 1'b0;
                        end
                    end else if (!HLDA) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Randomized bus-cycle and DMA stimulus against a transaction-level model of
// the address map, wait-state table and HOLD/HLDA handshake.
module tb_mem_bus_sequencer;

    logic        CLK = 1'b0;
    logic        RESET, ALE, IO_Mn, RDn, WRn, HLDA, DMA_REQ;
    logic [7:0]  AD_IN, A_HI;
    logic [15:0] ADDR_LATCHED;
    logic        READY, ROM_CSn, RAM_CSn, IO_CSn, HOLD, DMA_GNT, BUS_ERR;

    int n_chk  = 0;
    int n_pass = 0;

    mem_bus_sequencer dut (
        .CLK(CLK), .RESET(RESET), .ALE(ALE), .AD_IN(AD_IN), .A_HI(A_HI),
        .IO_Mn(IO_Mn), .RDn(RDn), .WRn(WRn), .HLDA(HLDA), .DMA_REQ(DMA_REQ),
        .ADDR_LATCHED(ADDR_LATCHED), .READY(READY), .ROM_CSn(ROM_CSn),
        .RAM_CSn(RAM_CSn), .IO_CSn(IO_CSn), .HOLD(HOLD), .DMA_GNT(DMA_GNT),
        .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [2:0] cs_now();
        return {ROM_CSn, RAM_CSn, IO_CSn};
    endfunction

    // Reference: address map and wait table written straight from the memory map.
    task automatic expect_access(input logic [15:0] a, input bit io, input bit rd, input bit wr,
                                 output logic [2:0] cs, output int n, output int err);
        cs = 3'b111; n = 0; err = 0;
        if (rd && wr)                          err = 1;
        else if (io)                           begin cs = 3'b110; n = 1; end
        else if (a <= 16'h07FF)                begin if (wr) err = 1; else begin cs = 3'b011; n = 2; end end
        else if (a >= 16'h2000 && a <= 16'h27FF) begin cs = 3'b101; n = 0; end
        else                                   err = 1;
    endtask

    task automatic latch_addr(input logic [15:0] a, input bit io);
        ALE = 1'b1; AD_IN = a[7:0]; A_HI = a[15:8]; IO_Mn = io;
        tick();
        ALE = 1'b0; AD_IN = 8'($urandom);
        chk("addr", 32'(ADDR_LATCHED), 32'(a));
    endtask

    // Runs the strobe phase of an already-latched cycle; optionally latches the
    // next address on the release edge.
    task automatic access(input logic [15:0] a, input bit io, input bit rd, input bit wr,
                          input bit chain, input logic [15:0] na, input bit nio);
        logic [2:0] ecs;
        int n, err, lo, errs, hold;
        expect_access(a, io, rd, wr, ecs, n, err);
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk("cs_pre", 32'(cs_now()), 32'(3'b111));
            chk("rdy_pre", 32'(READY), 32'd1);
        end
        RDn = !rd; WRn = !wr;
        hold = n + 1 + int'($urandom_range(0, 2));
        lo = 0; errs = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("cs", 32'(cs_now()), 32'(ecs));
            if (!READY) lo++;
            if (BUS_ERR) errs++;
        end
        chk("rdy_lo", 32'(lo), 32'(n));
        chk("bus_err", 32'(errs), 32'(err));
        RDn = 1'b1; WRn = 1'b1;
        if (chain) begin
            ALE = 1'b1; AD_IN = na[7:0]; A_HI = na[15:8]; IO_Mn = nio;
        end
        tick();
        chk("cs_rel", 32'(cs_now()), 32'(3'b111));
        chk("rdy_rel", 32'(READY), 32'd1);
        chk("hold_cpu", 32'(HOLD), 32'd0);
        if (chain) begin
            ALE = 1'b0;
            chk("chain_addr", 32'(ADDR_LATCHED), 32'(na));
        end
    endtask

    task automatic dma(input bit drop_early, input int d);
        logic [15:0] saved;
        saved = ADDR_LATCHED;
        DMA_REQ = 1'b1;
        tick();
        chk("hold_req", 32'(HOLD), 32'd1);
        chk("gnt_req", 32'(DMA_GNT), 32'd0);
        repeat (d) begin
            tick();
            chk("hold_wait", 32'(HOLD), 32'd1);
            chk("gnt_wait", 32'(DMA_GNT), 32'd0);
        end
        if (drop_early) begin
            DMA_REQ = 1'b0;
            tick();
            chk("hold_drop", 32'(HOLD), 32'd0);
            chk("gnt_drop", 32'(DMA_GNT), 32'd0);
        end else begin
            HLDA = 1'b1;
            tick();
            chk("gnt", 32'(DMA_GNT), 32'd1);
            chk("hold_gnt", 32'(HOLD), 32'd1);
            repeat ($urandom_range(1, 3)) begin
                ALE = 1'($urandom); AD_IN = 8'($urandom); A_HI = 8'($urandom);
                tick();
                chk("cs_dma", 32'(cs_now()), 32'(3'b111));
                chk("rdy_dma", 32'(READY), 32'd1);
                chk("addr_dma", 32'(ADDR_LATCHED), 32'(saved));
                chk("gnt_hold", 32'(DMA_GNT), 32'd1);
            end
            ALE = 1'b0; DMA_REQ = 1'b0;
            tick();
            chk("hold_rel", 32'(HOLD), 32'd0);
            chk("gnt_rel", 32'(DMA_GNT), 32'd0);
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("hold_hlda", 32'(HOLD), 32'd0);
                chk("gnt_hlda", 32'(DMA_GNT), 32'd0);
            end
            HLDA = 1'b0;
            tick();
        end
    endtask

    function automatic logic [15:0] rand_addr(input int kind);
        case (kind)
            0:       return 16'($urandom_range(16'h0000, 16'h07FF));
            1:       return 16'($urandom_range(16'h2000, 16'h27FF));
            2:       return 16'($urandom_range(16'h0800, 16'h1FFF));
            default: return 16'($urandom_range(16'h2800, 16'hFFFF));
        endcase
    endfunction

    initial begin
        logic [15:0] a, na;
        bit io, nio, rd, wr, chain, latched;
        int r;

        RESET = 1'b1; ALE = 1'b0; AD_IN = '0; A_HI = '0; IO_Mn = 1'b0;
        RDn = 1'b1; WRn = 1'b1; HLDA = 1'b0; DMA_REQ = 1'b0;
        repeat (2) tick();
        chk("rst_addr", 32'(ADDR_LATCHED), 32'h0);
        chk("rst_rdy", 32'(READY), 32'd1);
        chk("rst_cs", 32'(cs_now()), 32'(3'b111));
        chk("rst_hold", 32'(HOLD), 32'd0);
        chk("rst_gnt", 32'(DMA_GNT), 32'd0);
        chk("rst_err", 32'(BUS_ERR), 32'd0);
        RESET = 1'b0;
        tick();

        latch_addr(16'h0123, 1'b0); access(16'h0123, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        latch_addr(16'h2010, 1'b0); access(16'h2010, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        latch_addr(16'h0005, 1'b0); access(16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        latch_addr(16'h4000, 1'b0); access(16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        latch_addr(16'h4242, 1'b1); access(16'h4242, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        latch_addr(16'h2100, 1'b0); access(16'h2100, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);

        // Back-to-back: new ALE on the release edge skips IDLE.
        latch_addr(16'h2020, 1'b0); access(16'h2020, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0400, 1'b0);
        access(16'h0400, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);

        // ALE and DMA_REQ together: CPU cycle first, HOLD afterwards.
        DMA_REQ = 1'b1;
        latch_addr(16'h0123, 1'b0);
        chk("hold_ale", 32'(HOLD), 32'd0);
        access(16'h0123, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        dma(1'b0, 1);

        // Reset in the last ROM wait state.
        latch_addr(16'h0123, 1'b0);
        RDn = 1'b0;
        tick(); chk("rw_rdy0", 32'(READY), 32'd0);
        tick(); chk("rw_rdy1", 32'(READY), 32'd0);
        RESET = 1'b1;
        tick();
        chk("rr_rdy", 32'(READY), 32'd1);
        chk("rr_rom", 32'(ROM_CSn), 32'd1);
        chk("rr_addr", 32'(ADDR_LATCHED), 32'h0);
        RESET = 1'b0; RDn = 1'b1;
        tick();
        latch_addr(16'h2222, 1'b0); access(16'h2222, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

        latched = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (!latched && $urandom_range(0, 5) == 0) begin
                dma(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
                continue;
            end
            if (!latched) begin
                io = ($urandom_range(0, 4) == 0);
                a  = rand_addr(int'($urandom_range(0, 3)));
                latch_addr(a, io);
            end
            r  = int'($urandom_range(0, 9));
            rd = (r < 5) || (r == 9);
            wr = (r >= 5);
            chain = ($urandom_range(0, 3) == 0);
            nio = ($urandom_range(0, 4) == 0);
            na  = rand_addr(int'($urandom_range(0, 3)));
            access(a, io, rd, wr, chain, na, nio);
            latched = chain;
            if (chain) begin a = na; io = nio; end
        end
        if (latched) access(a, io, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
